// File: rtl/spi_link_transceiver_if.sv
// Core-side bundle between the packet sequencer and the SPI link transceiver.
// The sequencer uses the master modport and the transceiver uses the slave modport.
interface spi_link_transceiver_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_frame_err;

  modport master (
    output tx_start, tx_data,
    input  tx_busy, rx_data, rx_done, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data,
    output tx_busy, rx_data, rx_done, rx_frame_err
  );
endinterface

// File: rtl/spi_link_transceiver.sv
// Half-duplex byte SPI link: mode-0 master on the outbound pins while transmitting,
// synchronized slave receiver on the inbound pins otherwise.
module spi_link_transceiver #(
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  spi_link_transceiver_if.slave   core,
  output logic                    link_sclk_o,
  output logic                    link_mosi_o,
  output logic                    link_cs_n_o,
  input  logic                    link_sclk_i,
  input  logic                    link_mosi_i,
  input  logic                    link_cs_n_i
);

  typedef enum logic [2:0] {M_IDLE, M_SETUP, M_SHIFT, M_HOLD, M_GAP} m_state_e;

  localparam int            CW       = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);

  m_state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    half_q, half_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  // Master FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= M_IDLE;
      cnt_q      <= '0;
      half_q     <= '0;
      tx_shift_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  // Master FSM: next state
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    half_d     = half_q;
    tx_shift_d = tx_shift_q;
    unique case (state_q)
      M_IDLE: begin
        cnt_d = '0;
        if (core.tx_start) begin
          tx_shift_d = core.tx_data;
          state_d    = M_SETUP;
        end
      end
      M_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = M_SHIFT;
        end
      end
      M_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d  = '0;
          half_d = half_q + 4'd1;
          // Odd half-periods end on a falling SCLK edge; the final one keeps bit 0 on the pin.
          if (half_q[0] && half_q != 4'd15) tx_shift_d = {tx_shift_q[6:0], 1'b0};
          if (half_q == 4'd15) state_d = M_HOLD;
        end
      end
      M_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = M_GAP;
        end
      end
      M_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = M_IDLE;
        end
      end
      default: state_d = M_IDLE;
    endcase
  end

  // Master FSM: outputs
  logic cs_active;
  always_comb begin
    cs_active    = (state_q == M_SETUP) || (state_q == M_SHIFT) || (state_q == M_HOLD);
    core.tx_busy = (state_q != M_IDLE);
    link_cs_n_o  = !cs_active;
    link_mosi_o  = cs_active && tx_shift_q[7];
    link_sclk_o  = (state_q == M_SHIFT) && half_q[0];
  end

  // Inbound synchronizers; bit 0 takes the pin, the top bit is the synced value.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, csn_sync_q;
  logic                   sclk_prev_q, csn_prev_q;
  logic                   sclk_s, mosi_s, csn_s, sclk_rise, csn_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: synchronizers reset to the idle pin levels so no false edge follows reset.
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      csn_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], link_sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], link_mosi_i};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], link_cs_n_i};
      sclk_prev_q <= sclk_s;
      csn_prev_q  <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign csn_s     = csn_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_prev_q;
  assign csn_rise  = csn_s && !csn_prev_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_done_q, rx_done_d, rx_err_q, rx_err_d;

  // Slave receiver. The SCLK qualifier uses the previous cs_n so that a CS rise
  // landing on the 8th SCLK rise still completes the byte.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_done_d  = 1'b0;
    rx_err_d   = 1'b0;
    if (core.tx_busy) begin
      bit_cnt_d = '0;
    end else begin
      if (sclk_rise && !csn_prev_q) begin
        rx_shift_d = {rx_shift_q[5:0], mosi_s};
        if (bit_cnt_q == 3'd7) begin
          rx_data_d = {rx_shift_q, mosi_s};
          rx_done_d = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      if (csn_rise) begin
        rx_err_d  = (bit_cnt_d != 3'd0);
        bit_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_done_q  <= rx_done_d;
      rx_err_q   <= rx_err_d;
    end
  end

  assign core.rx_data      = rx_data_q;
  assign core.rx_done      = rx_done_q;
  assign core.rx_frame_err = rx_err_q;

endmodule

// File: tb/tb_spi_link_transceiver.sv
// Scoreboard bench for spi_link_transceiver: outbound bytes are decoded from the pins,
// inbound bytes are driven by a modelled remote master.
module tb_spi_link_transceiver;
  localparam int CLK_DIV     = 4;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic link_sclk_o, link_mosi_o, link_cs_n_o;
  logic link_sclk_i = 1'b0;
  logic link_mosi_i = 1'b0;
  logic link_cs_n_i = 1'b1;

  spi_link_transceiver_if core_if ();

  spi_link_transceiver #(.CLK_DIV(CLK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (core_if),
    .link_sclk_o (link_sclk_o),
    .link_mosi_o (link_mosi_o),
    .link_cs_n_o (link_cs_n_o),
    .link_sclk_i (link_sclk_i),
    .link_mosi_i (link_mosi_i),
    .link_cs_n_i (link_cs_n_i)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_seen     = 0;

  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outbound decoder: sample MOSI on each SCLK rise, compare completed bytes.
  initial begin
    logic [7:0] bits = '0;
    int         n    = 0;
    logic       prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || link_cs_n_o) begin
        n = 0;
      end else if (link_sclk_o && !prev) begin
        bits = {bits[6:0], link_mosi_o};
        n++;
        if (n == 8) begin
          n = 0;
          if (tx_exp.size() == 0) check("tx_unexpected_byte", {24'd0, bits}, 32'hFFFF_FFFF);
          else check("tx_byte", {24'd0, bits}, {24'd0, tx_exp.pop_front()});
        end
      end
      prev = link_sclk_o;
    end
  end

  // Inbound monitor: every rx_done must match the next queued byte.
  initial begin
    forever begin
      @(negedge clk);
      if (core_if.rx_done) begin
        if (rx_exp.size() == 0) check("rx_unexpected_done", {24'd0, core_if.rx_data}, 32'hFFFF_FFFF);
        else check("rx_byte", {24'd0, core_if.rx_data}, {24'd0, rx_exp.pop_front()});
      end
      if (core_if.rx_frame_err) err_seen++;
      if (core_if.rx_done && core_if.rx_frame_err) check("rx_done_err_exclusive", 32'd1, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic run_tx(input logic [7:0] b, input bit extra_start,
                        output int busy_cyc, output int csl_cyc);
    tx_exp.push_back(b);
    @(negedge clk);
    core_if.tx_start = 1'b1;
    core_if.tx_data  = b;
    busy_cyc = 0;
    csl_cyc  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0 && extra_start) begin
        core_if.tx_start = 1'b1;
        core_if.tx_data  = 8'hFE;
      end else begin
        core_if.tx_start = 1'b0;
      end
      if (core_if.tx_busy) busy_cyc++;
      if (!link_cs_n_o) csl_cyc++;
      if (i > 0 && !core_if.tx_busy) break;
    end
  endtask

  // Remote master: MSB-first, bits taken from the top of 'bits'.
  task automatic remote_frame(input logic [15:0] bits, input int nbits, input int hp);
    link_cs_n_i = 1'b0;
    repeat (hp) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      link_mosi_i = bits[15-i];
      repeat (hp) @(negedge clk);
      link_sclk_i = 1'b1;
      repeat (hp) @(negedge clk);
      link_sclk_i = 1'b0;
    end
    link_mosi_i = 1'b0;
    repeat (hp) @(negedge clk);
    link_cs_n_i = 1'b1;
    repeat (hp + SYNC_STAGES + 4) @(negedge clk);
  endtask

  initial begin
    int busy_cyc, csl_cyc, errs0, rises;
    logic prev;
    core_if.tx_start = 1'b0;
    core_if.tx_data  = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_tx_busy", {31'd0, core_if.tx_busy}, 32'd0);
    check("rst_rx_done", {31'd0, core_if.rx_done}, 32'd0);
    check("rst_rx_frame_err", {31'd0, core_if.rx_frame_err}, 32'd0);
    check("rst_rx_data", {24'd0, core_if.rx_data}, 32'h00);
    check("rst_sclk", {31'd0, link_sclk_o}, 32'd0);
    check("rst_mosi", {31'd0, link_mosi_o}, 32'd0);
    check("rst_cs_n", {31'd0, link_cs_n_o}, 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xCA with a second request one cycle later that must be dropped
    run_tx(8'hCA, 1'b1, busy_cyc, csl_cyc);
    check("tx_busy_cycles_ca", busy_cyc, 20 * CLK_DIV);
    check("tx_cs_low_cycles_ca", csl_cyc, 18 * CLK_DIV);
    repeat (10) @(negedge clk);
    check("tx_no_requeue", {31'd0, core_if.tx_busy}, 32'd0);
    check("tx_pending_ca", tx_exp.size(), 32'd0);

    run_tx(8'hFE, 1'b0, busy_cyc, csl_cyc);
    check("tx_busy_cycles_fe", busy_cyc, 20 * CLK_DIV);
    repeat (4) @(negedge clk);
    check("tx_pending_fe", tx_exp.size(), 32'd0);

    // Two back-to-back inbound bytes in one CS frame
    errs0 = err_seen;
    rx_exp.push_back(8'hCA);
    rx_exp.push_back(8'hFE);
    remote_frame(16'hCAFE, 16, 6);
    check("rx_pending_cafe", rx_exp.size(), 32'd0);
    check("rx_no_err_cafe", err_seen, errs0);

    // Short frame, then a clean byte
    errs0 = err_seen;
    remote_frame(16'hB000, 5, 6);
    check("rx_frame_err_count", err_seen, errs0 + 1);
    check("rx_data_held", {24'd0, core_if.rx_data}, 32'hFE);
    rx_exp.push_back(8'h5A);
    remote_frame(16'h5A00, 8, 6);
    check("rx_pending_5a", rx_exp.size(), 32'd0);
    check("rx_no_err_5a", err_seen, errs0 + 1);

    // Inbound traffic during a local transmit is not received
    errs0 = err_seen;
    fork
      run_tx(8'h77, 1'b0, busy_cyc, csl_cyc);
      begin
        @(negedge clk);
        remote_frame(16'h3300, 8, 4);
      end
    join
    repeat (8) @(negedge clk);
    check("loopback_busy_cycles", busy_cyc, 20 * CLK_DIV);
    check("loopback_no_err", err_seen, errs0);
    check("loopback_rx_data_held", {24'd0, core_if.rx_data}, 32'h5A);
    check("loopback_tx_pending", tx_exp.size(), 32'd0);
    rx_exp.push_back(8'h33);
    remote_frame(16'h3300, 8, 6);
    check("rx_pending_33", rx_exp.size(), 32'd0);

    // Reset in the middle of an outbound byte
    errs0 = err_seen;
    @(negedge clk);
    core_if.tx_start = 1'b1;
    core_if.tx_data  = 8'hA5;
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      core_if.tx_start = 1'b0;
      if (link_sclk_o && !prev) rises++;
      prev = link_sclk_o;
      if (rises == 4) break;
    end
    check("rst_mid_rises", rises, 32'd4);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_cs_n", {31'd0, link_cs_n_o}, 32'd1);
    check("rst_mid_sclk", {31'd0, link_sclk_o}, 32'd0);
    check("rst_mid_mosi", {31'd0, link_mosi_o}, 32'd0);
    check("rst_mid_tx_busy", {31'd0, core_if.tx_busy}, 32'd0);
    check("rst_mid_rx_data", {24'd0, core_if.rx_data}, 32'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_err", err_seen, errs0);

    run_tx(8'h01, 1'b0, busy_cyc, csl_cyc);
    check("tx_busy_cycles_01", busy_cyc, 20 * CLK_DIV);
    check("tx_cs_low_cycles_01", csl_cyc, 18 * CLK_DIV);
    repeat (4) @(negedge clk);
    check("tx_pending_01", tx_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_link_transceiver.md
# spi_link_transceiver

Byte-level, half-duplex SPI link engine between the packet sequencer and the board-to-board cable. On a transmit request it acts as SPI master (mode 0, MSB first) and shifts one byte out on the outbound pins. Otherwise it acts as SPI slave on the inbound pins and delivers each received byte with a one-cycle strobe. Its core-side ports map one-to-one onto the sequencer's spi_tx_start / spi_tx_data / spi_tx_busy / spi_rx_data / spi_rx_done.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period in master mode; must be ≥ 2.
- SYNC_STAGES, 2: synchronizer depth on the inbound pins; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- tx_start  in  1  one-cycle request to send tx_data; sampled only when not busy.
- tx_data  in  8  byte to send; latched on an accepted tx_start.
- tx_busy  out  1  high from the cycle after an accepted tx_start until the transfer and gap complete.
- rx_data  out  8  last complete received byte; held until the next byte.
- rx_done  out  1  one-cycle strobe; rx_data is valid in the same cycle.
- rx_frame_err  out  1  one-cycle strobe when link_cs_n_i rises with 1–7 bits captured.
- link_sclk_o  out  1  outbound SCLK, idle 0.
- link_mosi_o  out  1  outbound data.
- link_cs_n_o  out  1  outbound chip select, active low.
- link_sclk_i  in  1  inbound SCLK, asynchronous to clk.
- link_mosi_i  in  1  inbound data, asynchronous to clk.
- link_cs_n_i  in  1  inbound chip select, asynchronous to clk.

## Operation
- Reset values: tx_busy=0, rx_done=0, rx_frame_err=0, rx_data=0x00, link_sclk_o=0, link_mosi_o=0, link_cs_n_o=1. The master FSM goes to M_IDLE, the slave bit counter clears, and the synchronizer chains load their idle levels (sclk 0, mosi 0, cs_n 1).
- The master FSM has five states: M_IDLE, M_SETUP, M_SHIFT, M_HOLD, M_GAP.
  - M_IDLE: on tx_start, latch tx_data into the shift register and go to M_SETUP. tx_start while busy is ignored; no queueing.
  - M_SETUP: link_cs_n_o=0 and link_mosi_o=bit7. Lasts CLK_DIV cycles.
  - M_SHIFT: 16 half-periods of CLK_DIV cycles each; SCLK toggles at the end of each half-period. On every falling edge except the last, link_mosi_o advances to the next lower bit.
  - M_HOLD: SCLK=0, CS low, lasts CLK_DIV cycles. Then link_cs_n_o=1 and link_mosi_o=0.
  - M_GAP: CS high, lasts 2·CLK_DIV cycles, then return to M_IDLE.
  - tx_busy = (state != M_IDLE).
- Slave receiver:
  - Edge detection runs on the synchronized signals.
  - On a synced SCLK rising edge while synced cs_n=0: shift in synced mosi MSB-first and increment the bit counter (0–7).
  - When the 8th bit arrives, update rx_data, pulse rx_done, and wrap the counter to 0. More bytes in the same CS frame continue back-to-back.
  - A synced cs_n rising edge with counter ≠ 0 pulses rx_frame_err, discards the partial byte, and clears the counter. With counter=0 it only clears.
  - The receiver is gated off while tx_busy=1: edges are ignored and the counter is held at 0, so the half-duplex cable loopback is not received.
  - A CS frame already in progress when tx_busy rises is abandoned without rx_frame_err.

## Timing
- Accepted tx_start at edge T: tx_busy=1 and link_cs_n_o=0 from T+1. tx_busy falls at T+1+20·CLK_DIV (80 cycles for CLK_DIV=4).
- First SCLK rising edge at T+1+2·CLK_DIV. The remote slave samples on SCLK rising edges; data changes on falling edges (mode 0).
- rx_done latency: SYNC_STAGES+1 clk cycles after the physical 8th SCLK rising edge.
- Inbound requirements: SCLK high and low times ≥ SYNC_STAGES+2 clk cycles; MOSI stable ≥ 1 cycle either side of the rising edge.
- A synced CS rise in the same cycle as the 8th SCLK rise completes the byte: rx_done=1 and no rx_frame_err.
- rst mid-transfer: on the next edge all outputs return to reset values, with no rx_done and no rx_frame_err.
- rx_done and rx_frame_err are never both high in the same cycle.

## Test plan
- Reset, then tx_start with tx_data=0xCA and CLK_DIV=4 → tx_busy high for exactly 80 cycles. MOSI sampled on 8 SCLK rises reads 1,1,0,0,1,0,1,0; CS low for 72 cycles.
- Second tx_start one cycle after the first, with 0xFE → ignored; only 0xCA appears on the pins. A new tx_start with 0xFE after tx_busy falls sends 0xFE.
- Remote master drives 0xCA then 0xFE in one CS frame with a half-period of 6 cycles → two rx_done pulses with rx_data 0xCA then 0xFE, and rx_frame_err stays 0.
- Remote frame of 5 bits followed by CS rise → one rx_frame_err pulse, no rx_done, rx_data unchanged. The next full byte 0x5A is received correctly.
- Inbound byte 0x33 driven while the local master sends 0x77 → no rx_done during tx_busy. After tx_busy falls, a fresh inbound frame with 0x33 is received.
- Assert rst at the 4th SCLK rise of an outbound byte → next cycle link_cs_n_o=1, SCLK=0, tx_busy=0. A following tx_start of 0x01 transmits cleanly.
